// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// DataMem strobe values and the captured-request record.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  localparam logic [1:0] MEM_ACTIVE = 2'b01;
  localparam logic [1:0] MEM_IDLE   = 2'b00;

  // Request fields held for the life of one transaction.
  typedef struct packed {
    logic        write;
    lsu_size_e   size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane extract (load) and lane merge (store) for one 32-bit word.
// Byte lane = offset[1:0], half lane = offset[1].
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_size_e   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bsh      = {offset, 3'b000};
  assign hsh      = {offset[1], 4'b0000};
  assign byte_sel = word[bsh +: 8];
  assign half_sel = word[hsh +: 16];

  // Select/extend the addressed lane and build the read-modify-write word.
  always_comb begin
    load_val = word;
    merged   = word;
    case (size)
      SZ_BYTE: begin
        load_val       = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        merged[bsh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val        = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        merged[hsh +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_val = word;
        merged   = wdata;
      end
      default: begin
        load_val = '0;
        merged   = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word, little-endian,
// sub-word stores done as read-modify-write against a single-cycle DataMem.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// return an error instead of being forced to alignment).
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemWrite,
  output logic [1:0]  MemRead,
  input  logic [31:0] MemRData
);

  lsu_state_e  state, state_nxt;
  lsu_req_t    req_q;
  lsu_size_e   req_size;
  logic        accept;
  logic        misalign;
  logic        bad;
  logic [31:0] eff_addr;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_size = lsu_size_e'(ReqSize);
  assign ReqReady = (state == IDLE) && rst_n;
  assign accept   = ReqValid && ReqReady;
  assign RespValid = (state == RESP);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && ReqAddr[0]) ||
                    ((req_size == SZ_WORD) && (ReqAddr[1:0] != 2'b00));
  assign eff_addr = ReqAddr;
`else
  // Misaligned low bits are silently dropped; the access proceeds aligned.
  assign misalign = 1'b0;
  always_comb begin
    eff_addr = ReqAddr;
    if (req_size == SZ_HALF) eff_addr[0] = 1'b0;
    if (req_size == SZ_WORD) eff_addr[1:0] = 2'b00;
  end
`endif

  assign bad = (req_size == SZ_RSVD) || misalign;

  // Lanes operate on the live read word during RD.
  lsu_lane u_lane (
    .word        (MemRData),
    .size        (req_q.size),
    .offset      (req_q.addr[1:0]),
    .is_unsigned (req_q.uns),
    .wdata       (req_q.wdata),
    .load_val    (load_val),
    .merged      (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (bad)                                     state_nxt = RESP;
        else if (ReqWrite && (req_size == SZ_WORD))  state_nxt = WR;
        else                                         state_nxt = RD;
      end
      RD:      state_nxt = req_q.write ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (RespReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, DataMem strobes (one cycle, registered) and response data.
  // Reset clears the write strobe at once, so an aborted WR never reaches memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      RespData  <= '0;
      RespErr   <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemRead   <= MEM_IDLE;
      MemWrite  <= MEM_IDLE;
    end else begin
      MemRead  <= MEM_IDLE;
      MemWrite <= MEM_IDLE;
      case (state)
        IDLE: if (accept) begin
          req_q    <= '{write: ReqWrite, size: req_size, uns: ReqUnsigned,
                        addr: eff_addr, wdata: ReqWData};
          RespData <= '0;
          RespErr  <= bad;
          if (!bad) begin
            MemAddr <= {eff_addr[31:2], 2'b00};
            if (ReqWrite && (req_size == SZ_WORD)) begin
              MemWData <= ReqWData;
              MemWrite <= MEM_ACTIVE;
            end else begin
              MemRead <= MEM_ACTIVE;
            end
          end
        end
        RD: begin
          if (req_q.write) begin
            MemWData <= merged;
            MemWrite <= MEM_ACTIVE;
          end else begin
            RespData <= load_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid, ReqWrite, ReqUnsigned, RespReady;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqWData;
  logic        ReqReady, RespValid, RespErr;
  logic [31:0] RespData, MemAddr, MemWData, MemRData;
  logic [1:0]  MemWrite, MemRead;

  logic [31:0] mem [0:63];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int errors = 0;
  int checks = 0;
  int lat;
  int rd0, wr0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespErr(RespErr), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemRData(MemRData)
  );

  assign MemRData = mem[MemAddr[7:2]];

  always @(posedge clk) begin
    if (MemWrite == 2'b01) begin
      mem[MemAddr[7:2]] <= MemWData;
      wr_cnt <= wr_cnt + 1;
    end
    if (MemRead == 2'b01) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at the negedge, let the next posedge accept it.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
    ReqAddr = addr; ReqWData = wd;
    rd0 = rd_cnt; wr0 = wr_cnt;
    chk("req_ready_idle", {31'b0, ReqReady}, 32'd1);
    @(posedge clk); #1;
    ReqValid = 1'b0;
  endtask

  // Edges counted from acceptance (acceptance edge = 1) to first RespValid.
  task automatic wait_resp(output int l);
    l = 1;
    while (!RespValid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic finish_resp();
    @(negedge clk);
    RespReady = 1'b1;
    @(posedge clk); #1;
    RespReady = 1'b0;
  endtask

  task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_rd, input int exp_wr);
    issue(wr, sz, uns, addr, wd);
    wait_resp(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, RespData, exp_data);
    chk({tag, "_err"}, {31'b0, RespErr}, {31'b0, exp_err});
    finish_resp();
    chk({tag, "_reads"}, rd_cnt - rd0, exp_rd);
    chk({tag, "_writes"}, wr_cnt - wr0, exp_wr);
  endtask

  initial begin
    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
    ReqUnsigned = 1'b0; ReqAddr = '0; ReqWData = '0; RespReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("rst_resp_valid", {31'b0, RespValid}, 32'd0);
    chk("rst_resp_err", {31'b0, RespErr}, 32'd0);
    chk("rst_resp_data", RespData, 32'd0);
    chk("rst_mem_rw", {28'b0, MemRead, MemWrite}, 32'd0);
    chk("rst_mem_addr", MemAddr, 32'd0);
    chk("rst_mem_wdata", MemWData, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Preload through the DUT with word stores.
    access("st_w20", 1, 2'b10, 0, 32'd20, 32'h12345678, 2, 32'h0, 0, 0, 1);
    chk("mem20_pre", mem[5], 32'h12345678);
    access("ld_w20", 0, 2'b10, 0, 32'd20, 32'h0, 2, 32'h12345678, 0, 1, 0);
    access("ld_h20s", 0, 2'b01, 0, 32'd20, 32'h0, 2, 32'h00005678, 0, 1, 0);
    access("ld_b23u", 0, 2'b00, 1, 32'd23, 32'h0, 2, 32'h00000012, 0, 1, 0);

    access("st_w40", 1, 2'b10, 0, 32'd40, 32'h00A00000, 2, 32'h0, 0, 0, 1);
    access("ld_b42s", 0, 2'b00, 0, 32'd42, 32'h0, 2, 32'hFFFFFFA0, 0, 1, 0);
    access("ld_b42u", 0, 2'b00, 1, 32'd42, 32'h0, 2, 32'h000000A0, 0, 1, 0);
    access("ld_h42s", 0, 2'b01, 0, 32'd42, 32'h0, 2, 32'h000000A0, 0, 1, 0);

    // Sub-word read-modify-write stores.
    access("st_w20b", 1, 2'b10, 0, 32'd20, 32'h99999999, 2, 32'h0, 0, 0, 1);
    access("st_h22", 1, 2'b01, 0, 32'd22, 32'h0000EEEE, 3, 32'h0, 0, 1, 1);
    chk("mem20_h22", mem[5], 32'hEEEE9999);
    access("st_b21", 1, 2'b00, 0, 32'd21, 32'h00000055, 3, 32'h0, 0, 1, 1);
    chk("mem20_b21", mem[5], 32'hEEEE5599);
    access("ld_h22s", 0, 2'b01, 0, 32'd22, 32'h0, 2, 32'hFFFFEEEE, 0, 1, 0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    access("mis_w21", 0, 2'b10, 0, 32'd21, 32'h0, 1, 32'h0, 1, 0, 0);
`else
    access("mis_w21", 0, 2'b10, 0, 32'd21, 32'h0, 2, 32'hEEEE5599, 0, 1, 0);
    chk("mis_w21_addr", MemAddr, 32'd20);
`endif

    // Reserved size: immediate error, no memory traffic.
    access("rsvd", 0, 2'b11, 0, 32'd20, 32'h0, 1, 32'h0, 1, 0, 0);

    // Backpressure: response must hold while RespReady stays low.
    issue(0, 2'b10, 0, 32'd40, 32'h0);
    wait_resp(lat);
    chk("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, RespValid}, 32'd1);
      chk("bp_data", RespData, 32'h00A00000);
      chk("bp_req_ready", {31'b0, ReqReady}, 32'd0);
      chk("bp_mem_idle", {28'b0, MemRead, MemWrite}, 32'd0);
      chk("bp_mem_addr", MemAddr, 32'd40);
    end
    finish_resp();
    @(negedge clk);
    chk("bp_back_idle", {31'b0, ReqReady}, 32'd1);

    // Reset while the store write strobe is up: no write may land.
    issue(1, 2'b10, 0, 32'd40, 32'h77777777);
    chk("rstwr_in_wr", {30'b0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwr_mem_write", {30'b0, MemWrite}, 32'd0);
    chk("rstwr_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("rstwr_resp_valid", {31'b0, RespValid}, 32'd0);
    chk("rstwr_mem_addr", MemAddr, 32'd0);
    chk("rstwr_mem_wdata", MemWData, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstwr_mem40", mem[10], 32'h00A00000);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstwr_no_resp", {31'b0, RespValid}, 32'd0);
    chk("rstwr_ready", {31'b0, ReqReady}, 32'd1);
    access("post_rst_ld", 0, 2'b10, 0, 32'd40, 32'h0, 2, 32'h00A00000, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have request ports: ReqValid in 1 request present; ReqReady out 1 accepting; ReqWrite in 1 store=1/load=0; ReqSize in 2 00 byte, 01 half, 10 word, 11 reserved; ReqUnsigned in 1 zero-extend loads; ReqAddr in 32 byte address; ReqWData in 32 store data, right-justified.
REQ-003 SHALL have response ports: RespValid out 1 response present; RespReady in 1 consumer accepts; RespData out 32 extended load data, 0 for stores; RespErr out 1 misaligned or reserved size.
REQ-004 SHALL have DataMem-side ports: MemAddr out 32 word-aligned byte address; MemWData out 32 write word; MemWrite out 2, 01 = write; MemRead out 2, 01 = read; MemRData in 32 read word.

Function
REQ-005 SHALL implement FSM states IDLE, RD, WR, RESP.
REQ-006 SHALL assert ReqReady only in IDLE; a request is accepted on the edge where ReqValid and ReqReady are both 1, capturing all Req* fields.
REQ-007 Load SHALL transition IDLE->RD->RESP. Word store SHALL transition IDLE->WR->RESP. Byte/half store SHALL transition IDLE->RD->WR->RESP as a read-modify-write.
REQ-008 RD SHALL drive MemRead=01 and MemAddr={addr[31:2],2'b00} for exactly one cycle, capturing MemRData at the closing edge.
REQ-009 WR SHALL drive MemWrite=01 for exactly one cycle; MemWData SHALL be ReqWData for word stores, or the captured word with the addressed lane(s) replaced for sub-word stores.
REQ-010 Byte order SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-011 Load data SHALL be the selected lane shifted to bit 0, sign-extended unless ReqUnsigned=1; word loads pass unchanged.
REQ-012 RESP SHALL hold RespValid=1 with stable RespData/RespErr until RespReady=1, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-013 Latency from acceptance to RespValid SHALL be 2 cycles for loads and word stores, 3 for sub-word stores, and 1 for errors.
REQ-014 Outside RD/WR, MemRead and MemWrite SHALL be 00 and MemAddr/MemWData SHALL hold their last values.
REQ-015 Reserved size (11) SHALL go IDLE->RESP with RespErr=1 and no memory access.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, ReqReady=0 while asserted, RespValid=0, RespErr=0, RespData=0, MemRead=00, MemWrite=00, MemAddr=0, MemWData=0.
REQ-017 Reset during RD/WR SHALL abort the access with no partial write issued after reset assertion; the outstanding request is dropped without a response.

Configuration
REQ-018 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->RESP with RespErr=1 and no memory access.
REQ-019 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be cleared (half: addr[0]; word: addr[1:0]) and the access SHALL proceed normally with RespErr=0.

Structure
REQ-020 Package lsu_pkg SHALL hold the size encodings, the FSM state typedef, and constant MEM_ACTIVE=2'b01.
REQ-021 Lane extract/merge logic SHALL be a combinational sub-module lsu_lane (inputs: word, size, offset, unsigned flag, store data; outputs: extended load value, merged word).

Verification
REQ-022 Word load: preload mem[20]=0x12345678; load word addr 20 -> RespData=0x12345678 two cycles after acceptance, RespErr=0.
REQ-023 Signed/unsigned byte: mem[40]=0x00A0_0000; load byte addr 42 signed -> 0xFFFFFFA0; unsigned -> 0x000000A0.
REQ-024 Sub-word store: mem[20]=0x99999999; store half 0xEEEE at addr 22 -> exactly one MemRead then one MemWrite; mem[20]=0xEEEE9999; RespValid 3 cycles after acceptance.
REQ-025 Misalign: word load at addr 21 -> with LSU_MISALIGN_TRAP_EN: RespErr=1 after 1 cycle with no MemRead; without: reads addr 20, RespErr=0.
REQ-026 Backpressure/reset: hold RespReady=0 for 5 cycles -> RespValid/RespData stable and ReqReady=0; assert rst_n=0 during WR of a store to addr 40 -> outputs at reset values, mem[40] unchanged if reset precedes the WR edge.
